// File: rtl/viewport_sequencer.sv
// Viewport sequencer: derives camera origin/u/v from look-at vectors using one shared
// signed multiplier and a constant /225 divider, publishing results atomically.
module viewport_sequencer #(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               vp_hold,
    input  logic signed [19:0] lookat_rel_x,
    input  logic signed [19:0] lookat_rel_y,
    input  logic signed [19:0] lookat_rel_z,
    input  logic signed [19:0] lookat_h_rel_x,
    input  logic signed [19:0] lookat_h_rel_y,
    output logic signed [19:0] vp_origin_x,
    output logic signed [19:0] vp_origin_y,
    output logic signed [19:0] vp_origin_z,
    output logic signed [19:0] vp_u_x,
    output logic signed [19:0] vp_u_y,
    output logic signed [19:0] vp_u_z,
    output logic signed [19:0] vp_v_x,
    output logic signed [19:0] vp_v_y,
    output logic signed [19:0] vp_v_z,
    output logic               vp_valid,
    output logic               busy,
    output logic [7:0]         drop_cnt,
    output logic [3:0]         dbg_state
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_VX     = 4'd1;
    localparam logic [3:0] S_VY     = 4'd2;
    localparam logic [3:0] S_VZ0    = 4'd3;
    localparam logic [3:0] S_VZ1    = 4'd4;
    localparam logic [3:0] S_OX0    = 4'd5;
    localparam logic [3:0] S_OX1    = 4'd6;
    localparam logic [3:0] S_OY0    = 4'd7;
    localparam logic [3:0] S_OY1    = 4'd8;
    localparam logic [3:0] S_OZ     = 4'd9;
    localparam logic [3:0] S_COMMIT = 4'd10;

    localparam logic signed [19:0] H_K   = 20'(H_DISP);
    localparam logic signed [19:0] V_K   = 20'(V_DISP);
    localparam logic signed [47:0] DIV_K = 48'sd225;
    localparam logic signed [47:0] TWO   = 48'sd2;

    logic [3:0]         state_q, state_d;
    logic               pending_q, pending_d, valid_q, valid_d;
    logic [7:0]         drop_q, drop_d;
    logic signed [19:0] lx_q, ly_q, lz_q, ux_q, uy_q, lx_d, ly_d, lz_d, ux_d, uy_d;
    logic signed [47:0] acc_q, acc_d;
    logic signed [19:0] vx_q, vy_q, vz_q, ox_q, oy_q, oz_q, vx_d, vy_d, vz_d, ox_d, oy_d, oz_d;
    logic signed [19:0] pox_q, poy_q, poz_q, pux_q, puy_q, pvx_q, pvy_q, pvz_q;
    logic signed [19:0] pox_d, poy_d, poz_d, pux_d, puy_d, pvx_d, pvy_d, pvz_d;

    logic signed [19:0] mul_a, mul_b;
    logic signed [39:0] prod;
    logic signed [47:0] prod_w, num, quot, base, org;
    logic               capture, commit;

    // Shared datapath: operand select, one multiply, one /225 divide per state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        base  = '0;
        case (state_q)
            S_VX:    begin mul_a = uy_q; mul_b = lz_q; end
            S_VY:    begin mul_a = ux_q; mul_b = lz_q; end
            S_VZ0:   begin mul_a = ux_q; mul_b = ly_q; end
            S_VZ1:   begin mul_a = uy_q; mul_b = lx_q; end
            S_OX0:   begin mul_a = ux_q; mul_b = H_K;  end
            S_OX1:   begin mul_a = vx_q; mul_b = V_K; base = 48'(lx_q); end
            S_OY0:   begin mul_a = uy_q; mul_b = H_K;  end
            S_OY1:   begin mul_a = vy_q; mul_b = V_K; base = 48'(ly_q); end
            S_OZ:    begin mul_a = vz_q; mul_b = V_K; base = 48'(lz_q); end
            default: ;
        endcase
        prod   = 40'(mul_a) * 40'(mul_b);
        prod_w = 48'(prod);
        // Signed '/' truncates toward zero; the halving must not be a shift (that floors).
        case (state_q)
            S_VX:           num = prod_w;
            S_VY:           num = -prod_w;
            S_VZ1:          num = acc_q - prod_w;
            S_OX1, S_OY1:   num = (acc_q + prod_w) / TWO;
            S_OZ:           num = prod_w / TWO;
            default:        num = '0;
        endcase
        quot = num / DIV_K;
        org  = (base + quot) * TWO;
    end

    always_comb begin
        state_d = state_q;  pending_d = pending_q;  drop_d = drop_q;  valid_d = 1'b0;
        lx_d = lx_q;  ly_d = ly_q;  lz_d = lz_q;  ux_d = ux_q;  uy_d = uy_q;  acc_d = acc_q;
        vx_d = vx_q;  vy_d = vy_q;  vz_d = vz_q;  ox_d = ox_q;  oy_d = oy_q;  oz_d = oz_q;
        pox_d = pox_q;  poy_d = poy_q;  poz_d = poz_q;  pux_d = pux_q;  puy_d = puy_q;
        pvx_d = pvx_q;  pvy_d = pvy_q;  pvz_d = pvz_q;
        capture = 1'b0;
        commit  = 1'b0;

        if (frame_start && state_q != S_IDLE) begin
            if (!pending_q)            pending_d = 1'b1;
            else if (drop_q != 8'hFF)  drop_d    = drop_q + 8'd1;
        end

        case (state_q)
            S_IDLE:   if (frame_start || pending_q) capture = 1'b1;
            S_VX:     begin vx_d  = 20'(quot);  state_d = S_VY;   end
            S_VY:     begin vy_d  = 20'(quot);  state_d = S_VZ0;  end
            S_VZ0:    begin acc_d = prod_w;     state_d = S_VZ1;  end
            S_VZ1:    begin vz_d  = 20'(quot);  state_d = S_OX0;  end
            S_OX0:    begin acc_d = -prod_w;    state_d = S_OX1;  end
            S_OX1:    begin ox_d  = 20'(org);   state_d = S_OY0;  end
            S_OY0:    begin acc_d = -prod_w;    state_d = S_OY1;  end
            S_OY1:    begin oy_d  = 20'(org);   state_d = S_OZ;   end
            S_OZ:     begin oz_d  = 20'(org);   state_d = S_COMMIT; end
            S_COMMIT: if (!vp_hold) begin
                commit = 1'b1;
                if (pending_q) capture = 1'b1;
                else           state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase

        if (commit) begin
            pox_d = ox_q;  poy_d = oy_q;  poz_d = oz_q;  pux_d = ux_q;  puy_d = uy_q;
            pvx_d = vx_q;  pvy_d = vy_q;  pvz_d = vz_q;  valid_d = 1'b1;
        end
        // A queued request restarts on the same edge that leaves COMMIT.
        if (capture) begin
            pending_d = 1'b0;
            state_d   = S_VX;
            lx_d = lookat_rel_x;  ly_d = lookat_rel_y;  lz_d = lookat_rel_z;
            ux_d = lookat_h_rel_y;
            uy_d = -lookat_h_rel_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;  pending_q <= 1'b0;  drop_q <= '0;  valid_q <= 1'b0;
            lx_q <= '0;  ly_q <= '0;  lz_q <= '0;  ux_q <= '0;  uy_q <= '0;  acc_q <= '0;
            vx_q <= '0;  vy_q <= '0;  vz_q <= '0;  ox_q <= '0;  oy_q <= '0;  oz_q <= '0;
            pox_q <= '0;  poy_q <= '0;  poz_q <= '0;  pux_q <= '0;  puy_q <= '0;
            pvx_q <= '0;  pvy_q <= '0;  pvz_q <= '0;
        end else begin
            state_q <= state_d;  pending_q <= pending_d;  drop_q <= drop_d;  valid_q <= valid_d;
            lx_q <= lx_d;  ly_q <= ly_d;  lz_q <= lz_d;  ux_q <= ux_d;  uy_q <= uy_d;  acc_q <= acc_d;
            vx_q <= vx_d;  vy_q <= vy_d;  vz_q <= vz_d;  ox_q <= ox_d;  oy_q <= oy_d;  oz_q <= oz_d;
            pox_q <= pox_d;  poy_q <= poy_d;  poz_q <= poz_d;  pux_q <= pux_d;  puy_q <= puy_d;
            pvx_q <= pvx_d;  pvy_q <= pvy_d;  pvz_q <= pvz_d;
        end
    end

    assign vp_origin_x = pox_q;
    assign vp_origin_y = poy_q;
    assign vp_origin_z = poz_q;
    assign vp_u_x      = pux_q;
    assign vp_u_y      = puy_q;
    assign vp_u_z      = '0;
    assign vp_v_x      = pvx_q;
    assign vp_v_y      = pvy_q;
    assign vp_v_z      = pvz_q;
    assign vp_valid    = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign drop_cnt    = drop_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_viewport_sequencer.sv
// Self-checking bench for viewport_sequencer: directed scenarios plus random look-at
// vectors compared against an arithmetic model of the viewport equations.
module tb_viewport_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, frame_start, vp_hold;
    logic [19:0] lx, ly, lz, hx, hy;
    logic [19:0] vp_origin_x, vp_origin_y, vp_origin_z, vp_u_x, vp_u_y, vp_u_z;
    logic [19:0] vp_v_x, vp_v_y, vp_v_z;
    logic        vp_valid, busy;
    logic [7:0]  drop_cnt;
    logic [3:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;
    logic [179:0] last_vec = '0;
    logic [179:0] exp_q[$];
    logic [179:0] out_vec;

    always #5 clk = ~clk;

    viewport_sequencer dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .vp_hold(vp_hold),
        .lookat_rel_x(lx), .lookat_rel_y(ly), .lookat_rel_z(lz),
        .lookat_h_rel_x(hx), .lookat_h_rel_y(hy),
        .vp_origin_x(vp_origin_x), .vp_origin_y(vp_origin_y), .vp_origin_z(vp_origin_z),
        .vp_u_x(vp_u_x), .vp_u_y(vp_u_y), .vp_u_z(vp_u_z),
        .vp_v_x(vp_v_x), .vp_v_y(vp_v_y), .vp_v_z(vp_v_z),
        .vp_valid(vp_valid), .busy(busy), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    assign out_vec = {vp_origin_x, vp_origin_y, vp_origin_z, vp_u_x, vp_u_y, vp_u_z,
                      vp_v_x, vp_v_y, vp_v_z};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic longint sx(input logic [19:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [179:0] model(input logic [19:0] ilx, ily, ilz, ihx, ihy);
        logic [19:0] uxw, uyw, vxw, vyw, vzw, oxw, oyw, ozw;
        longint x, y, z, ux, uy;
        x = sx(ilx);  y = sx(ily);  z = sx(ilz);
        uxw = ihy;
        uyw = -ihx;
        ux = sx(uxw);  uy = sx(uyw);
        vxw = 20'((uy * z) / 225);
        vyw = 20'((-(ux * z)) / 225);
        vzw = 20'((ux * y - uy * x) / 225);
        oxw = 20'((x + ((-(ux * 1280) + sx(vxw) * 720) / 2) / 225) * 2);
        oyw = 20'((y + ((-(uy * 1280) + sx(vyw) * 720) / 2) / 225) * 2);
        ozw = 20'((z + ((sx(vzw) * 720) / 2) / 225) * 2);
        return {oxw, oyw, ozw, uxw, uyw, 20'd0, vxw, vyw, vzw};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [19:0] a, b, c, d, e);
        lx = a;  ly = b;  lz = c;  hx = d;  hy = e;
    endtask

    task automatic rand_inputs();
        set_in(20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
    endtask

    function automatic logic [19:0] small_val();
        int v;
        v = int'($urandom_range(0, 900)) - 450;
        return 20'(v);
    endfunction

    task automatic pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Returns the number of edges until vp_valid is seen, or -1 if the budget runs out.
    task automatic wait_valid(input int max_edges, input bit scramble, output int n);
        n = -1;
        for (int i = 1; i <= max_edges; i++) begin
            if (scramble) rand_inputs();
            step();
            if (vp_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;  frame_start = 1'b1;  vp_hold = 1'b0;
        set_in(20'd5, 20'd6, 20'd7, 20'd8, 20'd9);
        repeat (3) step();
        total++;
        if (out_vec !== '0 || vp_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_hold: out=%h valid=%b busy=%b drop=%0d want all zero",
                     out_vec, vp_valid, busy, drop_cnt);
        end
        frame_start = 1'b0;
        #2 rst_n = 1'b1;
        repeat (2) step();
        total++;
        if (busy !== 1'b0 || vp_valid !== 1'b0 || out_vec !== '0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_release: out=%h valid=%b busy=%b drop=%0d want idle zeros",
                     out_vec, vp_valid, busy, drop_cnt);
        end
    endtask

    task automatic test_forward();
        logic [179:0] e;
        logic [19:0]  want_uy, want_vz, want_ox, want_oz;
        int n;
        set_in(20'd225, 20'd0, 20'd0, 20'd225, 20'd0);
        e = model(lx, ly, lz, hx, hy);
        pulse();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL fwd_busy: got %b want 1", busy); end
        wait_valid(30, 1'b0, n);
        total++;
        if (n != 10) begin bad++; $display("FAIL fwd_latency: got %0d edges want 10", n); end
        total++;
        if (out_vec !== e) begin bad++; $display("FAIL fwd_out: got %h want %h", out_vec, e); end
        want_uy = 20'(-225);  want_vz = 20'd225;  want_ox = 20'd450;  want_oz = 20'd720;
        total++;
        if (vp_u_x !== 20'd0 || vp_u_y !== want_uy || vp_v_x !== 20'd0 || vp_v_y !== 20'd0 ||
            vp_v_z !== want_vz || vp_origin_x !== want_ox || vp_origin_z !== want_oz) begin
            bad++;
            $display("FAIL fwd_vectors: u=(%0d,%0d) v=(%0d,%0d,%0d) o=(%0d,_,%0d) want u=(0,-225) v=(0,0,225) o=(450,_,720)",
                     $signed(vp_u_x), $signed(vp_u_y), $signed(vp_v_x), $signed(vp_v_y),
                     $signed(vp_v_z), $signed(vp_origin_x), $signed(vp_origin_z));
        end
        last_vec = e;
        step();
        total++;
        if (vp_valid !== 1'b0 || busy !== 1'b0 || out_vec !== last_vec) begin
            bad++;
            $display("FAIL fwd_after: valid=%b busy=%b out=%h want 0 0 %h",
                     vp_valid, busy, out_vec, last_vec);
        end
    endtask

    task automatic test_rounding();
        logic [99:0] pats[4];
        logic [179:0] e;
        logic [99:0] p;
        int n;
        pats[0] = {20'd0, 20'd0, 20'(-225), 20'd1, 20'd0};
        pats[1] = {20'd7, 20'(-13), 20'd101, 20'(-3), 20'd5};
        pats[2] = {20'(-1), 20'(-1), 20'(-1), 20'd1, 20'd1};
        pats[3] = {20'(-300), 20'd157, 20'(-89), 20'd224, 20'(-17)};
        for (int k = 0; k < 4; k++) begin
            p = pats[k];
            set_in(p[99:80], p[79:60], p[59:40], p[39:20], p[19:0]);
            e = model(lx, ly, lz, hx, hy);
            pulse();
            wait_valid(30, 1'b0, n);
            total++;
            if (n != 10 || out_vec !== e) begin
                bad++;
                $display("FAIL round_%0d: edges=%0d got %h want 10 %h", k, n, out_vec, e);
            end
            last_vec = e;
        end
    endtask

    task automatic test_hold();
        logic [179:0] e;
        int frozen_bad;
        set_in(20'd120, 20'(-40), 20'd90, 20'd200, 20'd60);
        e = model(lx, ly, lz, hx, hy);
        pulse();
        repeat (3) step();
        vp_hold = 1'b1;
        frozen_bad = 0;
        for (int edge_no = 5; edge_no <= 17; edge_no++) begin
            step();
            if (vp_valid !== 1'b0 || out_vec !== last_vec || busy !== 1'b1) frozen_bad++;
        end
        total++;
        if (frozen_bad != 0) begin
            bad++;
            $display("FAIL hold_frozen: got %0d bad cycles want 0", frozen_bad);
        end
        vp_hold = 1'b0;
        step();
        total++;
        if (vp_valid !== 1'b1 || out_vec !== e) begin
            bad++;
            $display("FAIL hold_commit: valid=%b out=%h want 1 %h", vp_valid, out_vec, e);
        end
        last_vec = e;
        step();
    endtask

    task automatic test_coalesce();
        logic [179:0] ea, ec;
        int n;
        set_in(20'd225, 20'd30, 20'(-60), 20'd150, 20'd110);
        ea = model(lx, ly, lz, hx, hy);
        pulse();
        step();
        rand_inputs();
        pulse();
        step();
        rand_inputs();
        pulse();
        exp_drop++;
        step();
        pulse();
        exp_drop++;
        repeat (3) step();
        set_in(20'(-77), 20'd222, 20'd13, 20'(-199), 20'd64);
        ec = model(lx, ly, lz, hx, hy);
        step();
        total++;
        if (vp_valid !== 1'b1 || out_vec !== ea || busy !== 1'b1) begin
            bad++;
            $display("FAIL coal_first: valid=%b busy=%b out=%h want 1 1 %h",
                     vp_valid, busy, out_vec, ea);
        end
        rand_inputs();
        wait_valid(30, 1'b0, n);
        total++;
        if (n != 10 || out_vec !== ec) begin
            bad++;
            $display("FAIL coal_second: edges=%0d out=%h want 10 %h", n, out_vec, ec);
        end
        last_vec = ec;
        wait_valid(15, 1'b0, n);
        total++;
        if (n != -1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL coal_extra: extra valid after %0d edges busy=%b want none 0", n, busy);
        end
        total++;
        if (drop_cnt !== 8'(exp_drop)) begin
            bad++;
            $display("FAIL coal_drop: got %0d want %0d", drop_cnt, exp_drop);
        end
    endtask

    task automatic test_back_to_back();
        logic [179:0] ea, ec;
        int n;
        set_in(20'd50, 20'(-50), 20'd180, 20'd90, 20'(-120));
        ea = model(lx, ly, lz, hx, hy);
        pulse();
        repeat (9) step();
        rand_inputs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++;
        if (vp_valid !== 1'b1 || out_vec !== ea || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: valid=%b busy=%b out=%h want 1 0 %h",
                     vp_valid, busy, out_vec, ea);
        end
        set_in(20'(-210), 20'd3, 20'(-150), 20'(-44), 20'd201);
        ec = model(lx, ly, lz, hx, hy);
        wait_valid(30, 1'b0, n);
        total++;
        if (n != 11 || out_vec !== ec) begin
            bad++;
            $display("FAIL b2b_second: edges=%0d out=%h want 11 %h", n, out_vec, ec);
        end
        last_vec = ec;
        step();
        total++;
        if (drop_cnt !== 8'(exp_drop) || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drop: drop=%0d busy=%b want %0d 0", drop_cnt, busy, exp_drop);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        set_in(20'd99, 20'd88, 20'd77, 20'd66, 20'd55);
        pulse();
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_vec !== '0 || vp_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL midreset_clear: out=%h valid=%b busy=%b drop=%0d want zeros",
                     out_vec, vp_valid, busy, drop_cnt);
        end
        exp_drop = 0;
        last_vec = '0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(20, 1'b0, n);
        total++;
        if (n != -1 || out_vec !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_no_publish: valid after %0d edges out=%h busy=%b want none zero 0",
                     n, out_vec, busy);
        end
    endtask

    task automatic test_saturation();
        logic [179:0] ex, ey;
        bit pend;
        int n, sat_bad;
        set_in(20'd11, 20'd22, 20'd33, 20'd44, 20'd55);
        ex = model(lx, ly, lz, hx, hy);
        pulse();
        vp_hold = 1'b1;
        pend = 1'b0;
        sat_bad = 0;
        for (int i = 0; i < 300; i++) begin
            pulse();
            if (!pend) pend = 1'b1;
            else if (exp_drop < 255) exp_drop++;
            step();
            if (drop_cnt !== 8'(exp_drop)) sat_bad++;
        end
        total++;
        if (sat_bad != 0) begin
            bad++;
            $display("FAIL sat_track: got %0d mismatching cycles want 0", sat_bad);
        end
        total++;
        if (drop_cnt !== 8'd255 || busy !== 1'b1) begin
            bad++;
            $display("FAIL sat_final: drop=%0d busy=%b want 255 1", drop_cnt, busy);
        end
        set_in(20'(-5), 20'd140, 20'(-222), 20'd31, 20'd17);
        ey = model(lx, ly, lz, hx, hy);
        vp_hold = 1'b0;
        wait_valid(5, 1'b0, n);
        total++;
        if (n != 1 || out_vec !== ex) begin
            bad++;
            $display("FAIL sat_release: edges=%0d out=%h want 1 %h", n, out_vec, ex);
        end
        wait_valid(30, 1'b0, n);
        total++;
        if (n != 10 || out_vec !== ey || drop_cnt !== 8'd255) begin
            bad++;
            $display("FAIL sat_requeued: edges=%0d out=%h drop=%0d want 10 %h 255",
                     n, out_vec, drop_cnt, ey);
        end
        last_vec = ey;
        step();
    endtask

    task automatic test_random();
        logic [179:0] e;
        int n;
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 1) == 0)
                set_in(small_val(), small_val(), small_val(), small_val(), small_val());
            else
                rand_inputs();
            exp_q.push_back(model(lx, ly, lz, hx, hy));
            pulse();
            wait_valid(30, 1'b1, n);
            e = exp_q.pop_front();
            total++;
            if (n != 10 || out_vec !== e) begin
                bad++;
                $display("FAIL random_%0d: edges=%0d got %h want 10 %h", it, n, out_vec, e);
            end
            last_vec = e;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_rounding();
        test_hold();
        test_coalesce();
        test_back_to_back();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
